mirrored_ram: RTL

MIRRORED_RAM -- requirements
Module: mirrored_ram

---
 rtl/mirrored_ram.sv | 115 +++++++++++
 1 files changed

// File: rtl/mirrored_ram.sv
// Single-port RAM decoded into an address window, mirrored every 2^DEPTH_LOG2 words,
// with pipelined reads and a one-word-per-cycle clear sweep. Optional macro: MIRRORED_RAM_AUTOCLEAR_EN.
module mirrored_ram #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH_LOG2   = 11,
  parameter int                WINDOW_LOG2  = 13,
  parameter logic [ADDR_W-1:0] BASE         = '0,
  parameter int                READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              hit,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef MIRRORED_RAM_AUTOCLEAR_EN
  localparam logic AUTOCLEAR = 1'b1;
`else
  localparam logic AUTOCLEAR = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   sweep;
  logic                    init_pending;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    idle_access;
  logic                    wr_en;
  logic                    rd_launch;
  logic [READ_LATENCY-1:0] vpipe;
  logic [DATA_W-1:0]       dpipe [READ_LATENCY];

  assign hit   = (addr[ADDR_W-1:WINDOW_LOG2] == BASE[ADDR_W-1:WINDOW_LOG2]);
  assign idx   = addr[DEPTH_LOG2-1:0];

  // A pending clear (requested or post-reset) takes priority and drops the access.
  assign idle_access = (state == IDLE) && !init_pending && !clear && hit;
  assign wr_en       = idle_access && !rw;
  assign rd_launch   = idle_access && rw;

  generate
    if (WINDOW_LOG2 > DEPTH_LOG2) begin : g_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[WINDOW_LOG2-1:DEPTH_LOG2];
    end
  endgenerate

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sweep        <= '0;
      init_pending <= AUTOCLEAR;
    end else begin
      case (state)
        IDLE: begin
          if (init_pending || clear) begin
            state        <= CLEAR;
            busy         <= 1'b1;
            sweep        <= '0;
            init_pending <= 1'b0;
          end
        end
        CLEAR: begin
          sweep <= sweep + 1'b1;
          if (sweep == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array has no reset: contents survive nreset, only the sweep zeroes them.
  always_ff @(posedge clock) begin
    if (state == CLEAR) begin
      mem[sweep] <= '0;
    end else if (wr_en) begin
      mem[idx] <= data_in;
    end
  end

  // Read data is captured at launch, so a later sweep cannot corrupt in-flight reads.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      vpipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dpipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= rd_launch;
      dpipe[0] <= rd_launch ? mem[idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vpipe[i] <= vpipe[i-1];
        dpipe[i] <= dpipe[i-1];
      end
    end
  end

  assign rvalid   = vpipe[READ_LATENCY-1];
  assign data_out = dpipe[READ_LATENCY-1];

endmodule
